// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one bus transaction per legal access,
// stalls the pipeline while it is outstanding, and aborts after TIMEOUT busy cycles.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        stallM,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          access, legal;

  logic          bus_req_nx, bus_we_nx, rdata_valid_nx, err_nx;
  logic [31:0]   bus_addr_nx, bus_wdata_nx, rdata_nx, err_addr_nx;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      err_addr    <= 32'h0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bus_req     <= bus_req_nx;
      bus_we      <= bus_we_nx;
      bus_addr    <= bus_addr_nx;
      bus_wdata   <= bus_wdata_nx;
      rdata       <= rdata_nx;
      rdata_valid <= rdata_valid_nx;
      err         <= err_nx;
      err_addr    <= err_addr_nx;
    end
  end

  // Next-state, next-output and stall decode
  always_comb begin
    access         = (state == IDLE) && !flush && (mem_rd || mem_wr);
    legal          = access && (addr[1:0] == 2'b00) && !(mem_rd && mem_wr);
    stallM         = legal || (state == BUSY);

    state_nx       = state;
    cnt_nx         = cnt;
    bus_req_nx     = bus_req;
    bus_we_nx      = bus_we;
    bus_addr_nx    = bus_addr;
    bus_wdata_nx   = bus_wdata;
    rdata_nx       = rdata;
    rdata_valid_nx = 1'b0;
    err_nx         = 1'b0;
    err_addr_nx    = err_addr;

    case (state)
      IDLE: begin
        if (legal) begin
          bus_req_nx   = 1'b1;
          bus_we_nx    = mem_wr;
          bus_addr_nx  = addr;
          bus_wdata_nx = wdata;
          cnt_nx       = '0;
          state_nx     = BUSY;
        end else if (access) begin
          err_nx      = 1'b1;
          err_addr_nx = addr;
        end
      end
      BUSY: begin
        // An ack arriving on the timeout cycle still completes normally
        if (bus_ack) begin
          bus_req_nx     = 1'b0;
          if (!bus_we) rdata_nx = bus_rdata;
          rdata_valid_nx = !bus_we;
          state_nx       = DONE;
        end else if (cnt == LAST) begin
          bus_req_nx     = 1'b0;
          rdata_nx       = 32'h0;
          rdata_valid_nx = !bus_we;
          err_nx         = 1'b1;
          err_addr_nx    = bus_addr;
          state_nx       = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: the driver predicts each
// transaction's bus request and completion response, a monitor checks them.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        err;
    logic        rv;
    logic [31:0] rdata;
    logic [31:0] err_addr;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, flush = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_req, bus_we, stallM, rdata_valid, err;
  logic [31:0] bus_addr, bus_wdata, rdata, err_addr;

  int checks = 0;
  int failures = 0;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  bus_t  cur_bus;
  logic  prev_req = 1'b0;
  logic  started = 1'b0;

  // Reference state that persists between transactions
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_err_addr = 32'h0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .flush(flush),
    .addr(addr), .wdata(wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .stallM(stallM), .rdata(rdata), .rdata_valid(rdata_valid),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'h0);
    chk({tag, "_bus_we"}, 32'(bus_we), 32'h0);
    chk({tag, "_bus_addr"}, bus_addr, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  // Monitor: completion pulses and bus request launches are matched to predictions
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !started) begin
        prev_req = 1'b0;
      end else begin
        if (err || rdata_valid) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_response", {30'h0, err, rdata_valid}, 32'h0);
          end else begin
            resp_t e;
            e = resp_q.pop_front();
            chk("resp_err", 32'(err), 32'(e.err));
            chk("resp_rdata_valid", 32'(rdata_valid), 32'(e.rv));
            chk("resp_rdata", rdata, e.rdata);
            chk("resp_err_addr", err_addr, e.err_addr);
          end
        end
        if (bus_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_req", 32'(bus_req), 32'h0);
          end else begin
            cur_bus = bus_q.pop_front();
            chk("bus_addr", bus_addr, cur_bus.addr);
            chk("bus_we", 32'(bus_we), 32'(cur_bus.we));
            chk("bus_wdata", bus_wdata, cur_bus.wdata);
          end
        end else if (bus_req && prev_req) begin
          chk("bus_addr_stable", bus_addr, cur_bus.addr);
          chk("bus_wdata_stable", bus_wdata, cur_bus.wdata);
        end
        prev_req = bus_req;
      end
    end
  end

  // One MEM-stage request; ack_delay >= TO means the memory never answers
  task automatic do_txn(input logic rd, input logic wr, input logic fl,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_delay, input logic [31:0] rd_data);
    logic act, lg;
    int   exp_stall, n, busy_i, guard;
    resp_t r;
    bus_t  b;

    act = !fl && (rd || wr);
    lg  = act && (a[1:0] == 2'b00) && !(rd && wr);
    exp_stall = 0;
    if (lg) begin
      b.addr = a; b.we = wr; b.wdata = wd;
      bus_q.push_back(b);
      exp_stall = 1 + ((ack_delay < int'(TO)) ? ack_delay + 1 : int'(TO));
      if (ack_delay < int'(TO)) begin
        if (rd) begin
          m_rdata = rd_data;
          r.err = 1'b0; r.rv = 1'b1; r.rdata = m_rdata; r.err_addr = m_err_addr;
          resp_q.push_back(r);
        end
      end else begin
        m_rdata = 32'h0;
        m_err_addr = a;
        r.err = 1'b1; r.rv = rd; r.rdata = 32'h0; r.err_addr = a;
        resp_q.push_back(r);
      end
    end else if (act) begin
      m_err_addr = a;
      r.err = 1'b1; r.rv = 1'b0; r.rdata = m_rdata; r.err_addr = a;
      resp_q.push_back(r);
    end

    @(negedge clk);
    mem_rd = rd; mem_wr = wr; flush = fl; addr = a; wdata = wd; bus_ack = 1'b0;
    #1;
    n = 0;
    if (stallM) begin
      n = 1;
      busy_i = 0;
      guard = 0;
      @(negedge clk);
      // Pipeline inputs are don't-care while a transaction is outstanding
      mem_rd = 1'($urandom); mem_wr = 1'($urandom); flush = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      while (guard < 100) begin
        #1;
        if (!stallM) break;
        n++;
        bus_ack = (busy_i == ack_delay);
        bus_rdata = bus_ack ? rd_data : $urandom;
        busy_i++;
        guard++;
        @(negedge clk);
      end
      if (guard >= 100) chk("stall_release_timeout", 32'(guard), 32'h0);
      // Requests and acks during the completion cycle must be ignored
      mem_rd = 1'b1; mem_wr = 1'($urandom); flush = 1'b0;
      addr = $urandom & 32'hFFFF_FFFC; bus_ack = 1'($urandom); bus_rdata = $urandom;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    chk("reset_stallM", 32'(stallM), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Directed cases
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 0, 32'h0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, int'(TO), 32'h5555_AAAA);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0, int'(TO) - 1, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 0, 32'h0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 0, 32'h0BAD_C0DE);
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0064, 32'h0, 0, 32'h1111_2222);
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h8765_4321, int'(TO), 32'h0);

    // Reset while a load is outstanding drops the request without a clock edge
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b0; flush = 1'b0; addr = 32'h0000_0080; bus_ack = 1'b0;
    begin
      bus_t b;
      b.addr = 32'h0000_0080; b.we = 1'b0; b.wdata = wdata;
      bus_q.push_back(b);
    end
    @(negedge clk);
    mem_rd = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midbusy_reset");
    chk("midbusy_reset_stallM", 32'(stallM), 32'h0);
    m_rdata = 32'h0;
    m_err_addr = 32'h0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic rd, wr, fl;
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      if ($urandom_range(0, 15) == 0) begin rd = 1'b0; wr = 1'b0; end
      fl = ($urandom_range(0, 6) == 0);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn(rd, wr, fl, a, $urandom, int'($urandom_range(0, TO)), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum BUSY cycles allowed before abort (legal range 2..255).
REQ-002 The block SHALL have clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have mem_rd and mem_wr, input, 1 each, the load/store request decoded from the MEM-stage instruction.
REQ-005 The block SHALL have flush, input, 1; when high, it suppresses any new access from the MEM stage.
REQ-006 The block SHALL have addr and wdata, input, 32 each, the MEM-stage ALU result and store data.
REQ-007 The block SHALL have bus_ack, input, 1, and bus_rdata, input, 32, the memory-side completion and read data.
REQ-008 The block SHALL have bus_req, bus_we, output, 1 each; bus_addr and bus_wdata, output, 32 each; all registered.
REQ-009 The block SHALL have stallM, output, 1, which freezes the EX/MEM register and all earlier stages.
REQ-010 The block SHALL have rdata, output, 32, registered load result; rdata_valid, output, 1; err, output, 1; err_addr, output, 32.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY, DONE, and a timeout counter of 8 bits.
REQ-012 An access SHALL be defined as: state IDLE, flush=0, and mem_rd or mem_wr asserted.
REQ-013 A legal access SHALL have addr[1:0]=00 and SHALL NOT have mem_rd and mem_wr both high.
REQ-014 IDLE with a legal access: the block SHALL latch addr, wdata, and we=mem_wr onto the bus outputs, set bus_req=1 next cycle, and go to BUSY.
REQ-015 stallM SHALL be combinational: 1 in IDLE with a legal access, 1 in BUSY, 0 otherwise.
REQ-016 IDLE with an illegal access: no bus activity; err=1 for one cycle (next cycle); err_addr=addr; stallM=0; remain IDLE.
REQ-017 In BUSY, bus_req SHALL stay 1, and bus_addr/bus_wdata/bus_we SHALL stay stable until ack or timeout.
REQ-018 BUSY with bus_ack=1: bus_req=0 next cycle; rdata=bus_rdata if read, else rdata unchanged; go to DONE.
REQ-019 BUSY counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-020 Timeout: when the counter equals TIMEOUT-1 with no ack, the block SHALL drop bus_req, set rdata=0, err=1, err_addr=bus_addr, and go to DONE.
REQ-021 An ack in the same cycle as the timeout condition SHALL win (normal completion, no err).
REQ-022 DONE SHALL last exactly one cycle: stallM=0, rdata_valid=1 for reads (also on timeout); mem_rd/mem_wr ignored; next state IDLE.
REQ-023 Minimum legal access latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); stall cycles = 1 + BUSY cycles.
REQ-024 flush SHALL NOT abort a BUSY transaction; the transaction completes normally.
REQ-025 bus_ack in IDLE or DONE SHALL be ignored.
REQ-026 err and rdata_valid SHALL be single-cycle pulses; err_addr and rdata SHALL hold until next overwrite.

Reset
REQ-027 On rst=1 (asynchronous), the block SHALL set state=IDLE and counter=0, and drive bus_req, bus_we, rdata_valid, err to 0 and bus_addr, bus_wdata, rdata, err_addr to 32'h0.
REQ-028 Reset during BUSY SHALL drop bus_req immediately without waiting for a clock edge; the pending transaction is discarded.
REQ-029 After rst deasserts, the first access SHALL be accepted on the first rising edge.

Verification
REQ-030 Load, addr=32'h0000_0010, ack on 2nd BUSY cycle with bus_rdata=32'hDEAD_BEEF -> stallM high 3 cycles; rdata=32'hDEAD_BEEF; rdata_valid pulse in DONE.
REQ-031 Store, addr=32'h0000_0020, wdata=32'h1234_5678, immediate ack -> bus_we=1; bus_wdata=32'h1234_5678; stallM 2 cycles; no rdata_valid.
REQ-032 Load, addr=32'h0000_0013 -> err pulse; err_addr=32'h0000_0013; bus_req never asserted; stallM=0.
REQ-033 Load with no ack, TIMEOUT=4 -> bus_req high 4 cycles, then err=1; rdata=0; state IDLE after DONE.
REQ-034 rst asserted mid-BUSY -> bus_req=0 before the next edge; all outputs at reset values.
REQ-035 Back-to-back loads with flush=1 on the second -> first completes; second produces no bus_req and no stall.
